// File: rtl/pe_seq_pkg.sv
// rtl/pe_seq_pkg.sv - shared types, defaults and PE mask helper for the conv sequencer
package pe_seq_pkg;

    localparam int PE_DIM       = 8;
    localparam int PIPE_ADD_DEF = 1;
    localparam int PIPE_NL_DEF  = 1;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOADF,
        STREAM,
        DRAIN,
        DONE
    } seq_state_e;

    // Bit r*PE_DIM+c is set for every PE inside the top-left KxK window.
    function automatic logic [PE_DIM*PE_DIM-1:0] active_mask(input logic [3:0] k);
        logic [PE_DIM*PE_DIM-1:0] m;
        m = '0;
        for (int r = 0; r < PE_DIM; r++) begin
            for (int c = 0; c < PE_DIM; c++) begin
                m[r*PE_DIM+c] = (r < int'(k)) && (c < int'(k));
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pe_seq_window_counter.sv
// rtl/pe_seq_window_counter.sv - pixel col/row tracker flagging complete KxK windows
module pe_seq_window_counter #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    input  logic [ADDR_W-1:0] row_length,
    input  logic [ADDR_W-1:0] num_rows,
    input  logic [3:0]        kernel,
    output logic              window_valid,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col_end;
    logic [ADDR_W-1:0] row_end;
    logic [ADDR_W-1:0] k_m1;

    assign col_end = row_length - ONE;
    assign row_end = num_rows - ONE;
    assign k_m1    = {{(ADDR_W-4){1'b0}}, kernel} - ONE;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col == col_end) begin
                col <= '0;
                row <= row + ONE;
            end else begin
                col <= col + ONE;
            end
        end
    end

    assign window_valid = (col >= k_m1) && (row >= k_m1);
    assign last         = (col == col_end) && (row == row_end);

endmodule

// File: rtl/pe_array_conv_sequencer.sv
// rtl/pe_array_conv_sequencer.sv - drives PE array control strobes for one convolution pass
module pe_array_conv_sequencer
    import pe_seq_pkg::*;
#(
    parameter int N_PE     = PE_DIM,
    parameter int ADDR_W   = 10,
    parameter int PIPE_ADD = PIPE_ADD_DEF,
    parameter int PIPE_NL  = PIPE_NL_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      cfg_row_length,
    input  logic [ADDR_W-1:0]      cfg_num_rows,
    input  logic [3:0]             cfg_kernel,
    input  logic                   cfg_first_bank,
    input  logic                   cfg_final_bank,
    input  logic                   cfg_nl_en,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic [N_PE*N_PE-1:0]   shifting_line,
    output logic [N_PE*N_PE-1:0]   shifting_filter,
    output logic [N_PE*N_PE-1:0]   mac_enable,
    output logic [N_PE-1:0]        adder_enable,
    output logic [N_PE-1:0]        nl_enable,
    output logic [N_PE-1:0]        feedback_enable,
    output logic                   line_buffer_reset,
    output logic [ADDR_W-1:0]      row_length,
    output logic                   final_filter_bank,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int DRAIN_LEN = PIPE_ADD + PIPE_NL;
    localparam int DW        = $clog2(DRAIN_LEN + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LEN - 1);
    localparam logic [DW-1:0] D_ONE      = DW'(1);

    seq_state_e state;
    seq_state_e state_next;

    logic [ADDR_W-1:0] num_rows_q;
    logic [3:0]        kernel_q;
    logic              first_bank_q;
    logic              nl_en_q;
    logic [7:0]        fcnt;
    logic [7:0]        kk;
    logic [DW-1:0]     dcnt;
    logic [PIPE_ADD-1:0] add_pipe;
    logic [PIPE_NL-1:0]  nl_pipe;

    logic [ADDR_W-1:0]     cfg_k_ext;
    logic                  cfg_legal;
    logic                  filt_last;
    logic                  drain_end;
    logic                  window_valid;
    logic                  last_pixel;
    logic                  sf_fire;
    logic                  sl_fire;
    logic                  mac_fire;
    logic                  add_fire;
    logic                  nl_fire;
    logic [N_PE*N_PE-1:0]  pe_mask;
    logic [N_PE-1:0]       col_mask;

    assign cfg_k_ext = {{(ADDR_W-4){1'b0}}, cfg_kernel};
    assign cfg_legal = (cfg_kernel != 4'd0) && (int'(cfg_kernel) <= N_PE)
                     && (cfg_k_ext <= cfg_row_length) && (cfg_k_ext <= cfg_num_rows);

    assign kk        = {4'b0, kernel_q} * {4'b0, kernel_q};
    assign filt_last = (fcnt == kk - 8'd1);
    assign drain_end = (dcnt == DRAIN_LAST);
    assign pe_mask   = active_mask(kernel_q);
    assign col_mask  = pe_mask[N_PE-1:0];
    assign add_fire  = add_pipe[PIPE_ADD-1];
    assign nl_fire   = nl_pipe[PIPE_NL-1];

    pe_seq_window_counter #(.ADDR_W(ADDR_W)) u_window (
        .clk          (clk),
        .rst          (rst),
        .clear        (state == CLR),
        .advance      (sl_fire),
        .row_length   (row_length),
        .num_rows     (num_rows_q),
        .kernel       (kernel_q),
        .window_valid (window_valid),
        .last         (last_pixel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        data_ready        = 1'b0;
        sf_fire           = 1'b0;
        sl_fire           = 1'b0;
        mac_fire          = 1'b0;
        line_buffer_reset = 1'b0;
        done              = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = cfg_legal ? CLR : DONE;
                end
            end
            CLR: begin
                line_buffer_reset = 1'b1;
                state_next        = LOADF;
            end
            LOADF: begin
                data_ready = data_valid;
                sf_fire    = data_valid;
                if (data_valid && filt_last) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                data_ready = data_valid;
                sl_fire    = data_valid;
                mac_fire   = data_valid && window_valid;
                if (data_valid && last_pixel) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_end) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Config and error flag only change on a start accepted in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_length        <= '0;
            num_rows_q        <= '0;
            kernel_q          <= '0;
            first_bank_q      <= 1'b0;
            final_filter_bank <= 1'b0;
            nl_en_q           <= 1'b0;
            err               <= 1'b0;
            fcnt              <= '0;
            dcnt              <= '0;
            add_pipe          <= '0;
            nl_pipe           <= '0;
        end else begin
            if (state == IDLE && start) begin
                row_length        <= cfg_row_length;
                num_rows_q        <= cfg_num_rows;
                kernel_q          <= cfg_kernel;
                first_bank_q      <= cfg_first_bank;
                final_filter_bank <= cfg_final_bank;
                nl_en_q           <= cfg_nl_en;
                err               <= !cfg_legal;
            end
            if (state == LOADF) begin
                if (data_valid) begin
                    fcnt <= filt_last ? 8'd0 : fcnt + 8'd1;
                end
            end else begin
                fcnt <= '0;
            end
            if (state == DRAIN) begin
                dcnt <= dcnt + D_ONE;
            end else begin
                dcnt <= '0;
            end
            add_pipe[0] <= mac_fire;
            for (int i = 1; i < PIPE_ADD; i++) begin
                add_pipe[i] <= add_pipe[i-1];
            end
            nl_pipe[0] <= add_fire;
            for (int i = 1; i < PIPE_NL; i++) begin
                nl_pipe[i] <= nl_pipe[i-1];
            end
        end
    end

    assign busy            = (state != IDLE);
    assign shifting_filter = sf_fire  ? pe_mask : '0;
    assign shifting_line   = sl_fire  ? pe_mask : '0;
    assign mac_enable      = mac_fire ? pe_mask : '0;
    assign adder_enable    = add_fire ? col_mask : '0;
    assign feedback_enable = (add_fire && !first_bank_q) ? col_mask : '0;
    assign nl_enable       = (nl_fire && nl_en_q) ? col_mask : '0;
    assign out_valid       = nl_fire;

endmodule

// File: tb/tb_pe_array_conv_sequencer.sv
// tb/tb_pe_array_conv_sequencer.sv - scoreboard bench for pe_array_conv_sequencer
module tb_pe_array_conv_sequencer;

    localparam int N_PE   = 8;
    localparam int ADDR_W = 10;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [ADDR_W-1:0]    cfg_row_length;
    logic [ADDR_W-1:0]    cfg_num_rows;
    logic [3:0]           cfg_kernel;
    logic                 cfg_first_bank;
    logic                 cfg_final_bank;
    logic                 cfg_nl_en;
    logic                 data_valid;
    logic                 data_ready;
    logic [N_PE*N_PE-1:0] shifting_line;
    logic [N_PE*N_PE-1:0] shifting_filter;
    logic [N_PE*N_PE-1:0] mac_enable;
    logic [N_PE-1:0]      adder_enable;
    logic [N_PE-1:0]      nl_enable;
    logic [N_PE-1:0]      feedback_enable;
    logic                 line_buffer_reset;
    logic [ADDR_W-1:0]    row_length;
    logic                 final_filter_bank;
    logic                 out_valid;
    logic                 busy;
    logic                 done;
    logic                 err;

    pe_array_conv_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .cfg_row_length    (cfg_row_length),
        .cfg_num_rows      (cfg_num_rows),
        .cfg_kernel        (cfg_kernel),
        .cfg_first_bank    (cfg_first_bank),
        .cfg_final_bank    (cfg_final_bank),
        .cfg_nl_en         (cfg_nl_en),
        .data_valid        (data_valid),
        .data_ready        (data_ready),
        .shifting_line     (shifting_line),
        .shifting_filter   (shifting_filter),
        .mac_enable        (mac_enable),
        .adder_enable      (adder_enable),
        .nl_enable         (nl_enable),
        .feedback_enable   (feedback_enable),
        .line_buffer_reset (line_buffer_reset),
        .row_length        (row_length),
        .final_filter_bank (final_filter_bank),
        .out_valid         (out_valid),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    typedef struct {
        int lbr, sf, sl, mac, add, fb, nl, ov, err, lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cur_k   = 0;
    bit   dv_toggle = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int want);
        n_total++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, want);
    endtask

    function automatic logic [N_PE*N_PE-1:0] mask_of(input int k);
        logic [N_PE*N_PE-1:0] m;
        m = '0;
        for (int r = 0; r < N_PE; r++)
            for (int c = 0; c < N_PE; c++)
                if (r < k && c < k) m[r*N_PE+c] = 1'b1;
        return m;
    endfunction

    function automatic exp_t make_exp(input int k, input int rl, input int nr,
                                      input bit first, input bit nl, input int mac, input bit e_err);
        exp_t e;
        if (e_err) begin
            e = '{0, 0, 0, 0, 0, 0, 0, 0, 1, -1};
        end else begin
            e.lbr = 1; e.sf = k * k; e.sl = rl * nr; e.mac = mac; e.add = mac;
            e.fb = first ? 0 : mac; e.nl = nl ? mac : 0; e.ov = mac; e.err = 0; e.lat = 3;
        end
        return e;
    endfunction

    // Input data availability: constant or alternating every cycle.
    initial begin
        data_valid = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            data_valid = dv_toggle ? ~data_valid : 1'b1;
        end
    end

    // Monitor: accumulates strobe pulses per pass and scores them on done.
    initial begin
        int a_lbr, a_sf, a_sl, a_mac, a_add, a_fb, a_nl, a_ov, viol, cyc, last_sl;
        logic [N_PE*N_PE-1:0] m;
        logic [N_PE-1:0] cm;
        exp_t e;
        cyc = 0; last_sl = 0;
        {a_lbr, a_sf, a_sl, a_mac, a_add, a_fb, a_nl, a_ov, viol} = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                {a_lbr, a_sf, a_sl, a_mac, a_add, a_fb, a_nl, a_ov, viol} = '0;
                continue;
            end
            m  = mask_of(cur_k);
            cm = m[N_PE-1:0];
            if (line_buffer_reset) a_lbr++;
            if (|shifting_filter)  a_sf++;
            if (|shifting_line)    begin a_sl++; last_sl = cyc; end
            if (|mac_enable)       a_mac++;
            if (|adder_enable)     a_add++;
            if (|feedback_enable)  a_fb++;
            if (|nl_enable)        a_nl++;
            if (out_valid)         a_ov++;
            if (|((shifting_line | shifting_filter | mac_enable) & ~m)) viol++;
            if (|((adder_enable | feedback_enable | nl_enable) & ~cm)) viol++;
            if (|mac_enable && mac_enable != m) viol++;
            if (|shifting_line && shifting_line != m) viol++;
            if (!data_valid && (data_ready || |shifting_line || |shifting_filter || |mac_enable)) viol++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("lbr_pulses", a_lbr, e.lbr);
                    check("filter_pulses", a_sf, e.sf);
                    check("line_pulses", a_sl, e.sl);
                    check("mac_pulses", a_mac, e.mac);
                    check("adder_pulses", a_add, e.add);
                    check("feedback_pulses", a_fb, e.fb);
                    check("nl_pulses", a_nl, e.nl);
                    check("out_valid_pulses", a_ov, e.ov);
                    check("err_at_done", int'(err), e.err);
                    check("strobe_violations", viol, 0);
                    if (e.lat >= 0) check("done_latency", cyc - last_sl, e.lat);
                end
                {a_lbr, a_sf, a_sl, a_mac, a_add, a_fb, a_nl, a_ov, viol} = '0;
            end
        end
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 2000);
        if (!done) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic set_cfg(input int k, input int rl, input int nr, input bit first, input bit nl);
        cur_k          = k;
        cfg_kernel     = 4'(k);
        cfg_row_length = ADDR_W'(rl);
        cfg_num_rows   = ADDR_W'(nr);
        cfg_first_bank = first;
        cfg_nl_en      = nl;
        cfg_final_bank = 1'b1;
    endtask

    task automatic run_pass(input string name, input int k, input int rl, input int nr,
                            input bit first, input bit nl, input bit tog, input int mac, input bit e_err);
        set_cfg(k, rl, nr, first, nl);
        dv_toggle = tog;
        exp_q.push_back(make_exp(k, rl, nr, first, nl, mac, e_err));
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(name);
        @(posedge clk); #1;
    endtask

    logic any_out;
    assign any_out = data_ready | (|shifting_line) | (|shifting_filter) | (|mac_enable)
                   | (|adder_enable) | (|nl_enable) | (|feedback_enable) | line_buffer_reset
                   | (|row_length) | final_filter_bank | out_valid | busy | done | err;

    initial begin
        int n;
        rst = 1'b1; start = 1'b0;
        set_cfg(0, 0, 0, 1'b0, 1'b0);
        cfg_final_bank = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_zero", int'(any_out), 0);
        check("reset_busy", int'(busy), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_done", int'(done), 0);

        run_pass("k3_steady",     3, 5, 4, 1'b0, 1'b1, 1'b0, 6, 1'b0);
        check("row_length_latched", int'(row_length), 5);
        check("final_bank_latched", int'(final_filter_bank), 1);
        run_pass("k3_toggle",     3, 5, 4, 1'b0, 1'b1, 1'b1, 6, 1'b0);
        run_pass("k3_first_nlo",  3, 5, 4, 1'b1, 1'b0, 1'b0, 6, 1'b0);
        run_pass("k3_fb_nlo",     3, 5, 4, 1'b0, 1'b0, 1'b0, 6, 1'b0);
        run_pass("k9_illegal",    9, 10, 10, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        check("err_sticky", int'(err), 1);
        run_pass("k6_illegal",    6, 5, 8, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        run_pass("k2_clears_err", 2, 3, 3, 1'b0, 1'b1, 1'b0, 4, 1'b0);
        check("err_cleared", int'(err), 0);
        run_pass("k5_eq_row",     5, 5, 6, 1'b0, 1'b1, 1'b1, 2, 1'b0);

        // Abort mid-STREAM with reset: no done, all outputs cleared.
        set_cfg(3, 5, 4, 1'b0, 1'b1);
        dv_toggle = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("abort_busy_before", int'(busy), 1);
        check("abort_streaming", int'(|shifting_line), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_outputs_zero", int'(any_out), 0);
        @(posedge clk); #1 rst = 1'b0;
        n = 0;
        repeat (10) begin @(negedge clk); if (done) n++; end
        check("abort_no_done", n, 0);
        @(posedge clk); #1;
        run_pass("after_abort",   3, 5, 4, 1'b0, 1'b1, 1'b0, 6, 1'b0);

        // K=1 with start held across DONE: exactly one extra pass.
        set_cfg(1, 4, 2, 1'b0, 1'b1);
        exp_q.push_back(make_exp(1, 4, 2, 1'b0, 1'b1, 8, 1'b0));
        exp_q.push_back(make_exp(1, 4, 2, 1'b0, 1'b1, 8, 1'b0));
        @(posedge clk); #1 start = 1'b1;
        wait_done("hold_pass1");
        @(posedge clk);
        @(posedge clk); #1 start = 1'b0;
        wait_done("hold_pass2");
        @(posedge clk); #1;
        n = 0;
        repeat (20) begin @(negedge clk); if (busy) n++; end
        check("hold_no_third_pass", n, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pe_array_conv_sequencer.md
Name: pe_array_conv_sequencer

Overview:
Sequences one convolution pass of the PE array for one filter bank. It drives the array's control bundle: line/filter shift strobes, MAC/adder/non-linearity enables, feedback and line-buffer reset. It sits between the layer-level controller, which supplies configuration and start, and the PE array, whose data buses are driven elsewhere. It tracks pixel position so that MACs fire only on complete KxK windows, and it stalls on input-data availability.

Parameters:
N_PE, 8, PE array dimension; the array is N_PE x N_PE.
ADDR_W, 10, width of row_length and row counters; must match the codebase FIFO address width.
PIPE_ADD, 1, cycles from MAC strobe to adder strobe.
PIPE_NL, 1, cycles from adder strobe to nl/out strobe.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin pass; sampled only in IDLE
cfg_row_length  in  ADDR_W  pixels per input row
cfg_num_rows  in  ADDR_W  input rows
cfg_kernel  in  4  kernel size K, legal range 1..N_PE
cfg_first_bank  in  1  first filter bank; suppresses feedback
cfg_final_bank  in  1  last filter bank of the layer
cfg_nl_en  in  1  apply non-linearity
data_valid  in  1  bus word available this cycle (filter or pixel)
data_ready  out  1  word consumed this cycle
shifting_line  out  N_PE*N_PE  per-PE line shift, index r*N_PE+c
shifting_filter  out  N_PE*N_PE  per-PE filter shift
mac_enable  out  N_PE*N_PE  per-PE MAC strobe
adder_enable  out  N_PE  per-column adder strobe
nl_enable  out  N_PE  per-column non-linearity strobe
feedback_enable  out  N_PE  add previous partial sum
line_buffer_reset  out  1  clear line buffers
row_length  out  ADDR_W  registered cfg_row_length
final_filter_bank  out  1  registered cfg_final_bank
out_valid  out  1  result word present on output bus
busy  out  1  not IDLE
done  out  1  one-cycle completion pulse
err  out  1  sticky config error; cleared by next accepted start

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. On rst, every output is 0 and the state is IDLE. Reset mid-pass aborts at the next edge with no done pulse.
- Config is latched on the accepted start; config inputs are ignored while busy.
- Active PEs are those with r<K and c<K. Strobes to inactive PEs are always 0.
- States: IDLE -> CLR -> LOADF -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 with a legal config goes to CLR. A legal config means K in 1..N_PE, K<=cfg_row_length, K<=cfg_num_rows.
- Illegal config: go directly to DONE, set err=1, drive no strobes.
- CLR: line_buffer_reset=1 for exactly 1 cycle.
- LOADF: data_ready=data_valid. Each accepted word pulses shifting_filter on active PEs. After K*K accepted words, go to STREAM.
- STREAM: data_ready=data_valid. Each accepted pixel pulses shifting_line on active PEs and advances col, then row. col wraps at row_length-1; row increments on each col wrap.
- mac_enable pulses on active PEs in the same cycle as the pixel, only when col>=K-1 and row>=K-1.
- After the pixel at (num_rows-1, row_length-1) is accepted, go to DRAIN.
- data_valid=0 inserts bubbles: no strobes fire and the counters hold.
- Pipeline: adder_enable[c<K] repeats the MAC pulse delayed PIPE_ADD cycles.
- feedback_enable equals adder_enable when cfg_first_bank=0, else 0.
- nl_enable[c<K] equals adder_enable delayed PIPE_NL cycles, gated by cfg_nl_en.
- out_valid follows the same PIPE_ADD+PIPE_NL delay and is not gated by cfg_nl_en.
- DRAIN: lasts exactly PIPE_ADD+PIPE_NL cycles so all delayed strobes flush, then goes to DONE.
- DONE: done=1 for 1 cycle, then IDLE. busy=1 in every state except IDLE.
- Boundaries:
  - K=1: every pixel fires MAC.
  - K=row_length: one window per row once row>=K-1.
  - start held high through DONE: a new pass begins only from IDLE, i.e. the cycle after done.
- Expected number of MAC pulses per pass: (row_length-K+1)*(num_rows-K+1).

Decomposition:
- Package pe_seq_pkg holds:
  - state enum seq_state_e {IDLE, CLR, LOADF, STREAM, DRAIN, DONE};
  - the active-PE mask function active_mask(K), returning N_PE*N_PE bits;
  - the PIPE_* defaults.
- Sub-module pe_seq_window_counter: col/row counters with an advance input, a window_valid output (col>=K-1 && row>=K-1) and a last output. The sequencer instantiates it once.

Test Plan:
1. N_PE=8, K=3, row_length=5, num_rows=4, data_valid=1 constantly:
   - line_buffer_reset for 1 cycle, then 9 shifting_filter pulses, then 20 shifting_line pulses;
   - exactly 6 mac_enable pulses, mask bits only at r,c<3;
   - done exactly 2 cycles after the last pixel plus 1.
2. Same config with data_valid toggling 1010...:
   - identical pulse counts;
   - no strobes in cycles where data_valid=0.
3. cfg_first_bank=1 vs 0, cfg_nl_en=0:
   - feedback_enable pulses 0 vs 6 times;
   - nl_enable is never asserted;
   - out_valid pulses 6 times in both cases.
4. K=9 with N_PE=8, and K=6 with row_length=5:
   - DONE immediately, err=1, zero strobes;
   - the next legal start clears err.
5. rst asserted mid-STREAM:
   - all outputs 0 next cycle, busy=0, no done pulse;
   - a following start runs a full correct pass.
6. K=1, row_length=4, num_rows=2:
   - 8 MAC pulses, only on PE[0][0];
   - a start pulse held across DONE yields exactly one additional pass.
